// File: rtl/fifo_lector_rafagas_if.sv
// Read-side bus of the burst reader: FIFO read port plus the outgoing valid/ready stream.
interface fifo_lector_rafagas_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_vacio;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    // Reader side: consumes FIFO data, produces the stream.
    modport master (
        input  fifo_data_out,
        input  fifo_vacio,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    // Environment side: the FIFO and the downstream consumer.
    modport slave (
        output fifo_data_out,
        output fifo_vacio,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_lector_rafagas.sv
// Burst reader: drains a programmed number of words from a FIFO with one-cycle read latency
// and presents them on a valid/ready stream through a 3-entry skid buffer.
module fifo_lector_rafagas #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_burst_len,
    input  logic                  i_abort,
    fifo_lector_rafagas_if.master io_bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_W-1:0]      o_words_out
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [LEN_W-1:0] r_remaining;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf [3];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [1:0]       r_occ;
    logic [LEN_W-1:0] r_words;
    logic             r_zero_done;

    logic             w_rd_en;
    logic             w_drain_done;
    logic             w_push;
    logic             w_pop;
    logic             w_start_burst;
    logic             w_start_zero;
    logic [2:0]       w_outstanding;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_start_burst = (r_state == StIdle) && i_start && (i_burst_len != '0);
    assign w_start_zero  = (r_state == StIdle) && i_start && (i_burst_len == '0);
    // Data returned by the FIFO lands in the buffer the cycle after the read strobe.
    assign w_push        = r_inflight;
    assign w_pop         = (r_occ != 2'd0) && io_bus.m_ready;
    // Buffered plus in-flight words; reads stop at 3 so backpressure never drops data.
    assign w_outstanding = {1'b0, r_occ} + {2'b00, r_inflight};

    // Next-state and read-strobe decode; no path from m_ready into the read strobe.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_drain_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_burst) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_rd_en = io_bus.fifo_vacio && (r_remaining != '0) &&
                          (w_outstanding < 3'd3) && !i_abort;
                if (i_abort || (w_rd_en && (r_remaining == LEN_W'(1)))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if ((r_occ == 2'd0) && !r_inflight) begin
                    w_drain_done = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst bookkeeping: remaining reads, in-flight flag, zero-length done pulse, delivered count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_zero_done <= 1'b0;
            r_words     <= '0;
        end else begin
            if (w_start_burst) begin
                r_remaining <= i_burst_len;
            end else if (w_rd_en) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
            r_inflight  <= w_rd_en;
            r_zero_done <= w_start_zero;
            if (w_start_burst) begin
                r_words <= '0;
            end else if (w_pop) begin
                r_words <= r_words + LEN_W'(1);
            end
        end
    end

    // Output buffer: circular 3-entry store; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= io_bus.fifo_data_out;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign io_bus.fifo_rd_en = w_rd_en;
    assign io_bus.m_valid    = (r_occ != 2'd0);
    assign io_bus.m_data     = r_buf[r_rd_ptr];
    // busy drops in the same cycle as the completion pulse.
    assign o_busy            = (r_state == StRun) || ((r_state == StDrain) && !w_drain_done);
    assign o_done            = w_drain_done || r_zero_done;
    assign o_words_out       = r_words;

endmodule

// File: tb/tb_fifo_lector_rafagas.sv
// Directed bench for the burst reader with a behavioural one-cycle-latency FIFO.
module tb_fifo_lector_rafagas;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             abort;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_out;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_lector_rafagas_if #(.WIDTH(WIDTH)) bus ();

    fifo_lector_rafagas #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_burst_len (burst_len),
        .i_abort     (abort),
        .io_bus      (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_words_out (words_out)
    );

    always #5 clk = ~clk;

    // FIFO model: storage written by the stimulus, read pointer owned by the model.
    logic [WIDTH-1:0] fmem [64];
    logic [5:0]       f_wr = 6'd0;
    logic [5:0]       f_rd = 6'd0;
    logic             f_clr = 1'b0;

    assign bus.fifo_vacio = (f_wr != f_rd);
    assign bus.m_ready    = m_ready;

    always @(posedge clk) begin
        if (f_clr) begin
            f_rd <= f_wr;
        end else if (bus.fifo_rd_en && (f_wr != f_rd)) begin
            bus.fifo_data_out <= fmem[f_rd];
            f_rd              <= f_rd + 6'd1;
        end
    end

    // Monitor sampled mid-cycle: read strobes, underflows, stream transfers, done pulses.
    int               rd_cnt = 0;
    int               uf_cnt = 0;
    int               rx_cnt = 0;
    int               dn_cnt = 0;
    logic [WIDTH-1:0] rx [64];

    always @(negedge clk) begin
        if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.fifo_rd_en && !bus.fifo_vacio) uf_cnt <= uf_cnt + 1;
        if (bus.m_valid && m_ready) begin
            rx[rx_cnt[5:0]] <= bus.m_data;
            rx_cnt          <= rx_cnt + 1;
        end
        if (done) dn_cnt <= dn_cnt + 1;
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        fmem[f_wr] = d;
        f_wr       = f_wr + 6'd1;
    endtask

    task automatic flush();
        f_clr = 1'b1;
        next_cyc();
        f_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; burst_len = '0; abort = 1'b0; m_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); else n_pass++;
        n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_chk++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data: got %h want 00", bus.m_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_chk++; if (words_out !== 8'd0) $display("FAIL reset_words_out: got %0d want 0", words_out); else n_pass++;
        push(8'h5A);
        start = 1'b1; burst_len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_hold_rd_en c%0d: got %b want 0", i, bus.fifo_rd_en); else n_pass++;
        end
        start = 1'b0; burst_len = '0;
        next_cyc();
        rst = 1'b0;
        flush();
    endtask

    task automatic test_basic_burst();
        int base;
        base = rx_cnt;
        for (int i = 1; i <= 4; i++) push(8'hA0 + 8'(i));
        m_ready = 1'b1; start = 1'b1; burst_len = 8'd4;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            logic exp_rd, exp_v, exp_dn, exp_bsy;
            exp_rd  = (cyc >= 1 && cyc <= 4);
            exp_v   = (cyc >= 3 && cyc <= 6);
            exp_dn  = (cyc == 7);
            exp_bsy = (cyc >= 1 && cyc <= 6);
            @(negedge clk);
            n_chk++; if (bus.fifo_rd_en !== exp_rd) $display("FAIL basic_rd_en c%0d: got %b want %b", cyc, bus.fifo_rd_en, exp_rd); else n_pass++;
            n_chk++; if (bus.m_valid !== exp_v) $display("FAIL basic_m_valid c%0d: got %b want %b", cyc, bus.m_valid, exp_v); else n_pass++;
            n_chk++; if (done !== exp_dn) $display("FAIL basic_done c%0d: got %b want %b", cyc, done, exp_dn); else n_pass++;
            n_chk++; if (busy !== exp_bsy) $display("FAIL basic_busy c%0d: got %b want %b", cyc, busy, exp_bsy); else n_pass++;
            if (exp_v) begin
                n_chk++; if (bus.m_data !== 8'hA0 + 8'(cyc - 2)) $display("FAIL basic_m_data c%0d: got %h want %h", cyc, bus.m_data, 8'hA0 + 8'(cyc - 2)); else n_pass++;
            end
            next_cyc();
            start = 1'b0; burst_len = '0;
        end
        n_chk++; if (words_out !== 8'd4) $display("FAIL basic_words_out: got %0d want 4", words_out); else n_pass++;
        n_chk++; if (rx_cnt - base !== 4) $display("FAIL basic_rx_count: got %0d want 4", rx_cnt - base); else n_pass++;
    endtask

    task automatic test_empty_stall();
        int base, rd0, uf0;
        logic found;
        base = rx_cnt; rd0 = rd_cnt; uf0 = uf_cnt;
        push(8'hB1);
        m_ready = 1'b1; start = 1'b1; burst_len = 8'd3;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_chk++; if (bus.fifo_rd_en !== 1'b1) $display("FAIL stall_first_rd: got %b want 1", bus.fifo_rd_en); else n_pass++;
            end else if (!bus.fifo_vacio) begin
                n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL stall_gap_rd c%0d: got %b want 0", cyc, bus.fifo_rd_en); else n_pass++;
            end
            next_cyc();
            start = 1'b0; burst_len = '0;
        end
        n_chk++; if (rd_cnt - rd0 !== 1) $display("FAIL stall_gap_reads: got %0d want 1", rd_cnt - rd0); else n_pass++;
        push(8'hB2); push(8'hB3);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL stall_done_timeout: got %b want 1", found); else n_pass++;
        n_chk++; if (words_out !== 8'd3) $display("FAIL stall_words_at_done: got %0d want 3", words_out); else n_pass++;
        next_cyc();
        n_chk++; if (rx_cnt - base !== 3) $display("FAIL stall_rx_count: got %0d want 3", rx_cnt - base); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (rx[6'(base + i)] !== 8'hB1 + 8'(i)) $display("FAIL stall_order w%0d: got %h want %h", i, rx[6'(base + i)], 8'hB1 + 8'(i)); else n_pass++;
        end
        n_chk++; if (uf_cnt - uf0 !== 0) $display("FAIL stall_underflow: got %0d want 0", uf_cnt - uf0); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, rd0;
        logic found;
        base = rx_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        m_ready = 1'b0; start = 1'b1; burst_len = 8'd8;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) begin
                n_chk++; if (bus.m_valid !== 1'b1) $display("FAIL bp_valid c%0d: got %b want 1", cyc, bus.m_valid); else n_pass++;
                n_chk++; if (bus.m_data !== 8'hC0) $display("FAIL bp_hold c%0d: got %h want c0", cyc, bus.m_data); else n_pass++;
            end
            next_cyc();
            start = 1'b0; burst_len = '0;
        end
        n_chk++; if (rd_cnt - rd0 !== 3) $display("FAIL bp_reads_held: got %0d want 3", rd_cnt - rd0); else n_pass++;
        m_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL bp_done_timeout: got %b want 1", found); else n_pass++;
        next_cyc();
        n_chk++; if (rx_cnt - base !== 8) $display("FAIL bp_rx_count: got %0d want 8", rx_cnt - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (rx[6'(base + i)] !== 8'hC0 + 8'(i)) $display("FAIL bp_order w%0d: got %h want %h", i, rx[6'(base + i)], 8'hC0 + 8'(i)); else n_pass++;
        end
        n_chk++; if (words_out !== 8'd8) $display("FAIL bp_words_out: got %0d want 8", words_out); else n_pass++;
    endtask

    task automatic test_zero_len();
        int rd0;
        rd0 = rd_cnt;
        push(8'h77);
        start = 1'b1; burst_len = 8'd0;
        for (int cyc = 0; cyc <= 2; cyc++) begin
            logic exp_dn;
            exp_dn = (cyc == 1);
            @(negedge clk);
            n_chk++; if (done !== exp_dn) $display("FAIL zero_done c%0d: got %b want %b", cyc, done, exp_dn); else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL zero_busy c%0d: got %b want 0", cyc, busy); else n_pass++;
            next_cyc();
            start = 1'b0;
        end
        n_chk++; if (rd_cnt - rd0 !== 0) $display("FAIL zero_reads: got %0d want 0", rd_cnt - rd0); else n_pass++;
        flush();
    endtask

    task automatic test_abort();
        int base, rd0;
        logic found;
        base = rx_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) push(8'hD0 + 8'(i));
        m_ready = 1'b1; start = 1'b1; burst_len = 8'd10;
        next_cyc();
        start = 1'b0; burst_len = '0;
        next_cyc();
        next_cyc();
        abort = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL abort_rd_en: got %b want 0", bus.fifo_rd_en); else n_pass++;
        next_cyc();
        abort = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL abort_done_timeout: got %b want 1", found); else n_pass++;
        next_cyc();
        n_chk++; if (rd_cnt - rd0 !== 2) $display("FAIL abort_reads: got %0d want 2", rd_cnt - rd0); else n_pass++;
        n_chk++; if (rx_cnt - base !== 2) $display("FAIL abort_rx_count: got %0d want 2", rx_cnt - base); else n_pass++;
        n_chk++; if (rx[6'(base)] !== 8'hD0) $display("FAIL abort_w0: got %h want d0", rx[6'(base)]); else n_pass++;
        n_chk++; if (rx[6'(base + 1)] !== 8'hD1) $display("FAIL abort_w1: got %h want d1", rx[6'(base + 1)]); else n_pass++;
        n_chk++; if (words_out !== 8'd2) $display("FAIL abort_words_out: got %0d want 2", words_out); else n_pass++;
        flush();
    endtask

    task automatic test_rst_mid_burst();
        int dn0;
        dn0 = dn_cnt;
        for (int i = 0; i < 10; i++) push(8'hE0 + 8'(i));
        m_ready = 1'b1; start = 1'b1; burst_len = 8'd10;
        next_cyc();
        start = 1'b0; burst_len = '0;
        repeat (3) next_cyc();
        @(negedge clk);
        n_chk++; if (bus.m_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", bus.m_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (bus.fifo_rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", bus.fifo_rd_en); else n_pass++;
        n_chk++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_chk++; if (bus.m_data !== 8'h00) $display("FAIL rstmid_m_data: got %h want 00", bus.m_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (words_out !== 8'd0) $display("FAIL rstmid_words_out: got %0d want 0", words_out); else n_pass++;
        repeat (2) next_cyc();
        rst = 1'b0;
        flush();
        repeat (6) next_cyc();
        n_chk++; if (dn_cnt - dn0 !== 0) $display("FAIL rstmid_no_done: got %0d want 0", dn_cnt - dn0); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_empty_stall();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_rst_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_lector_rafagas.md
Name: fifo_lector_rafagas

Overview:
- Read-side controller for the team's synchronous FIFO. It drains a programmed burst of words from the FIFO read port and presents them on a valid/ready stream.
- It honours the FIFO's active-low empty flag and one-cycle read latency, so the FIFO can never underflow.
- It sits between the FIFO's read port and any downstream consumer, and is the counterpart of the writer that fills the FIFO.

Parameters:
- WIDTH, 8, data word width; must match the FIFO SIZE.
- LEN_W, 8, width of the burst length and the words-delivered counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  in  LEN_W  number of words to read; sampled with start.
- abort  in  1  stop issuing reads; words already read are still delivered.
- fifo_data_out  in  WIDTH  FIFO DATA_OUT; valid the cycle after fifo_rd_en.
- fifo_vacio  in  1  FIFO F_EMPTY_N; 1 = at least one word present.
- fifo_rd_en  out  1  FIFO READ strobe.
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- busy  out  1  burst in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse at burst completion.
- words_out  out  LEN_W  words delivered in current/last burst.

Behaviour:
- Reset (async, rst=1): state IDLE; fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, words_out=0. Buffer and in-flight flag cleared; in-flight FIFO data is discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1, burst_len!=0 -> RUN next cycle; latch remaining=burst_len; clear words_out.
  - start=1, burst_len=0 -> done=1 next cycle, stay IDLE, no reads.
- RUN:
  - fifo_rd_en = fifo_vacio & (remaining!=0) & (occ + inflight < 3) & !abort. It is combinational from registered state and fifo_vacio only; there is no path from m_ready.
  - Each fifo_rd_en cycle: remaining-1; inflight=1 next cycle.
  - The cycle after fifo_rd_en, fifo_data_out is written into a 3-entry output buffer at the end of that cycle.
  - remaining reaches 0, or abort=1 -> DRAIN.
- DRAIN:
  - No reads are issued.
  - When occ=0 and inflight=0: done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
- Output buffer (3 entries, in-order):
  - m_valid = (occ != 0); m_data = oldest entry.
  - A transfer occurs when m_valid & m_ready; words_out increments by 1 (no wrap within a burst, since words_out <= burst_len).
  - m_data and m_valid are held stable while m_valid=1 and m_ready=0.
  - Simultaneous write and pop in the same cycle: occ unchanged, order preserved.
- Throughput and latency:
  - Sustains 1 word/cycle with m_ready=1 and the FIFO non-empty.
  - Start sampled at edge 0 -> first fifo_rd_en in cycle 1 -> first m_valid in cycle 3.
- Empty FIFO: fifo_rd_en is never 1 while fifo_vacio=0. Reads resume in the same cycle fifo_vacio rises.
- Backpressure: at most 3 words are outstanding (buffered + in flight), so no data is lost.
- start during busy: ignored. abort in IDLE or DRAIN: ignored.
- rst mid-burst: immediate return to reset values; the partial burst is discarded with no done pulse.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously; fifo_rd_en stays 0 with fifo_vacio=1.
- Basic burst: FIFO holds A1,A2,A3,A4; start, burst_len=4, m_ready=1 -> expected response:
  - fifo_rd_en=1 in cycles 1-4;
  - m_valid=1 in cycles 3-6 with data A1..A4;
  - done=1 in cycle 7; words_out=4.
- Empty stall: burst_len=3, FIFO holds 1 word, next words pushed 10 cycles later -> fifo_rd_en=0 throughout the gap; 3 words delivered in order; done after the third.
- Backpressure: burst_len=8 with m_ready=0 for 8 cycles -> exactly 3 fifo_rd_en pulses; m_data held at the first word; on release, all 8 words delivered in order with no duplicates.
- Zero length: start, burst_len=0 -> done=1 next cycle; no fifo_rd_en; busy stays 0.
- Abort/reset: abort after 2 reads of burst_len=10 -> exactly 2 words delivered, then done; repeat with rst instead -> no done, outputs 0.
